// File: rtl/fifo_wr_arb.sv
// Purpose: round-robin arbiter that lets NUM_REQ requesters write bursts into one shared FIFO.
// Latency: 0 cycles; a beat is written to the FIFO in the same cycle its ack is high.
// Backpressure: fifo_full suppresses every ack. A burst holds its grant while stalled and releases it when the owner drops req.
//
// Ports:
//   clk, rst              rising-edge clock; synchronous active-high reset
//   req/req_last/req_data per-requester beat valid, end-of-packet flag and data (DATA_WIDTH slice per requester)
//   ack                   one-hot or zero; the acked beat is written this cycle
//   fifo_wr_en/_data      write port of the shared FIFO; data is 0 when nothing is written
//   fifo_full             full flag from the shared FIFO
//   owner                 current burst owner, or the most recent grantee
//   busy                  high while a burst holds the grant
// Build option: FIFO_ARB_PRIO0_EN gives requester 0 absolute priority whenever no burst is in progress.
module fifo_wr_arb #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_full,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic                          busy
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST) + 1;

`ifdef FIFO_ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] rr_ptr, rr_ptr_nxt;
    logic [PW-1:0] owner_q, owner_nxt;
    logic [CW-1:0] beat_cnt, beat_cnt_nxt;
    logic [PW-1:0] sel;
    logic          sel_vld;
    logic [PW-1:0] gnt_idx;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        return (i == PW'(NUM_REQ - 1)) ? '0 : i + PW'(1);
    endfunction

    // With the priority option, grants to requester 0 leave the
    // round-robin pointer alone so the other requesters keep their order.
    function automatic logic ptr_moves(input logic [PW-1:0] i);
        return !(PRIO0 && (i == '0));
    endfunction

    // Cyclic scan from rr_ptr. Walking from the far end backwards lets the
    // nearest requester overwrite the others, so the first hit wins.
    always_comb begin
        int idx;
        sel     = '0;
        sel_vld = 1'b0;
        idx     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx]) begin
                sel     = PW'(idx);
                sel_vld = 1'b1;
            end
        end
        if (PRIO0 && req[0]) begin
            sel     = '0;
            sel_vld = 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        owner_nxt    = owner_q;
        beat_cnt_nxt = beat_cnt;
        ack          = '0;
        gnt_idx      = owner_q;
        case (state)
            IDLE: begin
                gnt_idx = sel;
                if (sel_vld && !fifo_full) begin
                    ack[sel]  = 1'b1;
                    owner_nxt = sel;
                    if (req_last[sel] || (MAX_BURST == 1)) begin
                        if (ptr_moves(sel)) begin
                            rr_ptr_nxt = next_idx(sel);
                        end
                    end else begin
                        state_nxt    = BURST;
                        beat_cnt_nxt = CW'(1);
                    end
                end
            end
            BURST: begin
                if (!req[owner_q]) begin
                    // Owner went quiet: give the grant back and skip past it.
                    state_nxt    = IDLE;
                    beat_cnt_nxt = '0;
                    if (ptr_moves(owner_q)) begin
                        rr_ptr_nxt = next_idx(owner_q);
                    end
                end else if (!fifo_full) begin
                    ack[owner_q] = 1'b1;
                    if (req_last[owner_q] || (beat_cnt + CW'(1) == CW'(MAX_BURST))) begin
                        // Packet done or burst cap hit; a capped requester
                        // simply re-arbitrates for the rest of its packet.
                        state_nxt    = IDLE;
                        beat_cnt_nxt = '0;
                        if (ptr_moves(owner_q)) begin
                            rr_ptr_nxt = next_idx(owner_q);
                        end
                    end else begin
                        beat_cnt_nxt = beat_cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Reset acts in the same cycle so a burst in flight writes nothing.
        if (rst) begin
            ack = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner_q  <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            owner_q  <= owner_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    assign fifo_wr_en   = |ack;
    assign fifo_wr_data = fifo_wr_en ? req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign busy         = (state == BURST) && !rst;
    assign owner        = rst ? '0 : owner_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb with NUM_REQ=4, MAX_BURST=4, DATA_WIDTH=8.
// Inputs change on the falling edge; outputs are checked 2 time units later, before the next rising edge.
// Expectations after the round-robin step assume the default build, in which the priority option is off.
module tb_fifo_wr_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        fifo_full;
    logic [1:0]  owner;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fifo_wr_arb #(
        .DATA_WIDTH(8),
        .NUM_REQ   (4),
        .MAX_BURST (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_last    (req_last),
        .req_data    (req_data),
        .ack         (ack),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .fifo_full   (fifo_full),
        .owner       (owner),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] lst,
                         input logic full, input logic [31:0] d);
        @(negedge clk);
        rst       = r;
        req       = rq;
        req_last  = lst;
        fifo_full = full;
        req_data  = d;
        #2;
    endtask

    task automatic outs(input string tag, input logic [3:0] e_ack, input logic [7:0] e_data,
                        input logic e_busy);
        chk({tag, ".ack"},   32'(ack),          32'(e_ack));
        chk({tag, ".wr_en"}, 32'(fifo_wr_en),   32'(|e_ack));
        chk({tag, ".data"},  32'(fifo_wr_data), 32'(e_data));
        chk({tag, ".busy"},  32'(busy),         32'(e_busy));
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        req_data  = '0;

        // Reset holds everything quiet even with all requesters asking.
        drive(1'b1, 4'b1111, 4'b1111, 1'b0, 32'hA3A2A1A0);
        outs("rst0", 4'b0000, 8'h00, 1'b0);
        chk("rst0.owner", 32'(owner), 32'd0);
        drive(1'b1, 4'b1111, 4'b1111, 1'b0, 32'hA3A2A1A0);
        outs("rst1", 4'b0000, 8'h00, 1'b0);

        // Single-beat packets from everyone: grants rotate 0,1,2,3.
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 4'b1111, 4'b1111, 1'b0, 32'hA3A2A1A0);
`ifdef FIFO_ARB_PRIO0_EN
            outs($sformatf("rr%0d", k), 4'b0001, 8'hA0, 1'b0);
`else
            outs($sformatf("rr%0d", k), 4'(1 << k), 8'(8'hA0 + k), 1'b0);
`endif
        end

        // Requester 1 streams a 6-beat packet while requester 2 waits.
        // The burst is cut at 4 beats, 2 gets one beat, then 1 finishes.
        drive(1'b0, 4'b0110, 4'b0100, 1'b0, 32'h00551000);
        chk("cap1.owner", 32'(owner), 32'd3);
        outs("cap1", 4'b0010, 8'h10, 1'b0);
        drive(1'b0, 4'b0110, 4'b0100, 1'b0, 32'h00551100);
        outs("cap2", 4'b0010, 8'h11, 1'b1);
        drive(1'b0, 4'b0110, 4'b0100, 1'b0, 32'h00551200);
        outs("cap3", 4'b0010, 8'h12, 1'b1);
        drive(1'b0, 4'b0110, 4'b0100, 1'b0, 32'h00551300);
        outs("cap4", 4'b0010, 8'h13, 1'b1);
        drive(1'b0, 4'b0110, 4'b0100, 1'b0, 32'h00551400);
        outs("cap5", 4'b0100, 8'h55, 1'b0);
        drive(1'b0, 4'b0010, 4'b0000, 1'b0, 32'h00551400);
        chk("cap6.owner", 32'(owner), 32'd2);
        outs("cap6", 4'b0010, 8'h14, 1'b0);
        drive(1'b0, 4'b0010, 4'b0010, 1'b0, 32'h00551500);
        outs("cap7", 4'b0010, 8'h15, 1'b1);

        // Requester 3 burst with a 3-cycle full stall after the first beat.
        // The stall must not count as beats, so the cap lands after 0x33.
        drive(1'b0, 4'b1000, 4'b0000, 1'b0, 32'h30000000);
        outs("full1", 4'b1000, 8'h30, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 4'b1000, 4'b0000, 1'b1, 32'h31000000);
            outs($sformatf("stall%0d", k), 4'b0000, 8'h00, 1'b1);
        end
        drive(1'b0, 4'b1000, 4'b0000, 1'b0, 32'h31000000);
        outs("full2", 4'b1000, 8'h31, 1'b1);
        drive(1'b0, 4'b1000, 4'b0000, 1'b0, 32'h32000000);
        outs("full3", 4'b1000, 8'h32, 1'b1);
        drive(1'b0, 4'b1000, 4'b0000, 1'b0, 32'h33000000);
        outs("full4", 4'b1000, 8'h33, 1'b1);
        drive(1'b0, 4'b1000, 4'b1000, 1'b0, 32'h34000000);
        outs("full5", 4'b1000, 8'h34, 1'b0);

        // Requester 0 starts a burst, then drops req for a cycle; the pointer
        // moves to 1 so requester 1 wins even though 0 asks again.
        drive(1'b0, 4'b0001, 4'b0000, 1'b0, 32'h00000040);
        outs("drop1", 4'b0001, 8'h40, 1'b0);
        drive(1'b0, 4'b0010, 4'b0010, 1'b0, 32'h00001140);
        outs("drop2", 4'b0000, 8'h00, 1'b1);
        drive(1'b0, 4'b0011, 4'b0010, 1'b0, 32'h00001140);
        outs("drop3", 4'b0010, 8'h11, 1'b0);

        // Reset on beat 2 of requester 2's burst: no write that cycle, then
        // arbitration restarts at index 0.
        drive(1'b0, 4'b0101, 4'b0000, 1'b0, 32'h00200040);
        outs("mrst1", 4'b0100, 8'h20, 1'b0);
        drive(1'b1, 4'b0101, 4'b0000, 1'b0, 32'h00210040);
        outs("mrst2", 4'b0000, 8'h00, 1'b0);
        chk("mrst2.owner", 32'(owner), 32'd0);
        drive(1'b0, 4'b0101, 4'b0001, 1'b0, 32'h00220040);
        outs("mrst3", 4'b0001, 8'h40, 1'b0);

        // Full while idle: nothing granted and the pointer (now 1) is kept.
        drive(1'b0, 4'b1111, 4'b1111, 1'b1, 32'h44332211);
        outs("ifull1", 4'b0000, 8'h00, 1'b0);
        drive(1'b0, 4'b1111, 4'b1111, 1'b0, 32'h44332211);
        outs("ifull2", 4'b0010, 8'h22, 1'b0);
        chk("ifull2.owner", 32'(owner), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
